// File: rtl/debug_cmd_engine.sv
// debug_cmd_engine: parses multi-byte debug commands from the inbound FIFO,
// executes them and streams a framed response (opcode, status, payload)
// into the outbound FIFO.
module debug_cmd_engine #(
   parameter int LEDCount      = 4,
   parameter int CounterWidth  = 32,
   parameter int EchoMax       = 4,
   parameter int TimeoutCycles = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                in_r,
   input  logic [7:0]          in_rd,
   input  logic                in_rok,
   output logic                out_w,
   output logic [7:0]          out_wd,
   input  logic                out_wok,
   output logic [LEDCount-1:0] led,
   output logic                busy
);

   localparam int CntBytes = CounterWidth / 8;
   localparam int PayMax   = (CntBytes > EchoMax) ? CntBytes : EchoMax;
   localparam int BufLen   = PayMax + 2;
   localparam int IW       = $clog2(BufLen + 1);
   localparam int TW       = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

   localparam logic [7:0] OP_NOP     = 8'h00;
   localparam logic [7:0] OP_LEDOFF  = 8'h80;
   localparam logic [7:0] OP_LEDON   = 8'h81;
   localparam logic [7:0] OP_LEDSET  = 8'h82;
   localparam logic [7:0] OP_ECHO    = 8'h83;
   localparam logic [7:0] OP_RDCNT   = 8'h84;

   localparam logic [7:0] ST_OK      = 8'h01;
   localparam logic [7:0] ST_UNKNOWN = 8'h02;
   localparam logic [7:0] ST_TIMEOUT = 8'h03;
   localparam logic [7:0] ST_BADLEN  = 8'h04;

   typedef enum logic [1:0] {S_IDLE, S_ARG, S_EXEC, S_RESP} state_e;

   state_e                  state_q, state_d;
   logic                    run_q;
   logic [7:0]              op_q, status_q, arg_q;
   logic [3:0]              argn_q;
   logic [TW-1:0]           tmo_q;
   logic [7:0]              echo_q [EchoMax];
   logic [7:0]              buf_q  [BufLen];
   logic [IW-1:0]           blen_q, idx_q;
   logic [LEDCount-1:0]     led_q;
   logic [CounterWidth-1:0] cnt_q;

   logic       xfer_in, xfer_out, tmo_hit, last_byte, len_bad;
   logic [7:0] pay [PayMax];

   assign xfer_in   = in_r && in_rok;
   assign xfer_out  = out_w && out_wok;
   assign tmo_hit   = (TimeoutCycles > 0) && (int'(tmo_q) == TimeoutCycles - 1);
   assign last_byte = (idx_q == blen_q - IW'(1));
   assign len_bad   = in_rd > 8'(EchoMax);

   // Payload candidates: counter bytes MSB first, or the echo bytes in order.
   always_comb begin
      for (int i = 0; i < PayMax; i++) pay[i] = 8'h00;
      if (op_q == OP_RDCNT) begin
         for (int i = 0; i < CntBytes; i++) pay[i] = cnt_q[8*(CntBytes-1-i) +: 8];
      end else begin
         for (int i = 0; i < EchoMax; i++) pay[i] = echo_q[i];
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (xfer_in && in_rd != OP_NOP)
                    state_d = (in_rd == OP_LEDSET || in_rd == OP_ECHO) ? S_ARG : S_EXEC;
         S_ARG: begin
            if (xfer_in) begin
               if (op_q == OP_LEDSET)                         state_d = S_EXEC;
               else if (argn_q == 4'd0) begin
                  if (in_rd == 8'h00 || len_bad)               state_d = S_EXEC;
               end else if ({4'b0, argn_q} == arg_q)          state_d = S_EXEC;
            end else if (tmo_hit) begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: state_d = S_RESP;
         S_RESP: if (xfer_out && last_byte) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs; in_r stays low until the first edge after reset release.
   always_comb begin
      in_r   = run_q && (state_q == S_IDLE || state_q == S_ARG);
      out_w  = (state_q == S_RESP);
      out_wd = buf_q[idx_q];
      busy   = (state_q != S_IDLE);
      led    = led_q;
   end

   // Datapath: parsing, timeout, execution side effects and response buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q    <= 1'b0;
         cnt_q    <= '0;
         op_q     <= '0;
         status_q <= '0;
         arg_q    <= '0;
         argn_q   <= '0;
         tmo_q    <= '0;
         led_q    <= '0;
         blen_q   <= '0;
         idx_q    <= '0;
         for (int i = 0; i < EchoMax; i++) echo_q[i] <= '0;
         for (int i = 0; i < BufLen; i++)  buf_q[i]  <= '0;
      end else begin
         run_q <= 1'b1;
         cnt_q <= cnt_q + 1'b1;
         case (state_q)
            S_IDLE: if (xfer_in && in_rd != OP_NOP) begin
               op_q     <= in_rd;
               status_q <= (in_rd >= OP_LEDOFF && in_rd <= OP_RDCNT) ? ST_OK : ST_UNKNOWN;
               argn_q   <= '0;
               tmo_q    <= '0;
            end
            S_ARG: begin
               if (xfer_in) begin
                  tmo_q  <= '0;
                  argn_q <= argn_q + 4'd1;
                  if (argn_q == 4'd0) begin
                     arg_q <= in_rd;
                     if (op_q == OP_ECHO && len_bad) status_q <= ST_BADLEN;
                  end
                  // Payload byte k arrives with argn_q == k+1.
                  for (int i = 0; i < EchoMax; i++)
                     if (op_q == OP_ECHO && int'(argn_q) == i + 1) echo_q[i] <= in_rd;
               end else if (tmo_hit) begin
                  status_q <= ST_TIMEOUT;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            S_EXEC: begin
               if (status_q == ST_OK) begin
                  case (op_q)
                     OP_LEDOFF: led_q[0] <= 1'b0;
                     OP_LEDON:  led_q[0] <= 1'b1;
                     OP_LEDSET: led_q    <= arg_q[LEDCount-1:0];
                     default: ;
                  endcase
               end
               buf_q[0] <= op_q;
               buf_q[1] <= status_q;
               for (int i = 0; i < PayMax; i++) buf_q[i+2] <= pay[i];
               if (status_q != ST_OK)   blen_q <= IW'(2);
               else if (op_q == OP_RDCNT) blen_q <= IW'(2 + CntBytes);
               else if (op_q == OP_ECHO)  blen_q <= IW'(2) + IW'(arg_q);
               else                       blen_q <= IW'(2);
               idx_q <= '0;
            end
            S_RESP: if (xfer_out && !last_byte) idx_q <= idx_q + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_cmd_engine.sv
// Directed bench for debug_cmd_engine: vector table plus hand-written
// sequences for counter read, argument timeout, counter wrap and mid-response reset.
module tb_debug_cmd_engine;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_rd;
   logic       in_rok, out_wok, in_rok2, out_wok2;
   logic       in_r, out_w, busy, in_r2, out_w2, busy2;
   logic [7:0] out_wd, out_wd2;
   logic [3:0] led, led2;

   int checks = 0;
   int failures = 0;
   logic [31:0] tb_cnt;
   logic [7:0]  got [$];

   debug_cmd_engine #(.LEDCount(4), .CounterWidth(32), .EchoMax(4), .TimeoutCycles(1024)) dut (
      .clk(clk), .rst_n(rst_n), .in_r(in_r), .in_rd(in_rd), .in_rok(in_rok),
      .out_w(out_w), .out_wd(out_wd), .out_wok(out_wok), .led(led), .busy(busy));

   // Narrow-counter instance used to observe counter wrap in reasonable time.
   debug_cmd_engine #(.LEDCount(4), .CounterWidth(8), .EchoMax(4), .TimeoutCycles(1024)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_r(in_r2), .in_rd(in_rd), .in_rok(in_rok2),
      .out_w(out_w2), .out_wd(out_wd2), .out_wok(out_wok2), .led(led2), .busy(busy2));

   always #5 clk = ~clk;

   // Reference cycle counter: zero in reset, +1 per clock afterwards.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) tb_cnt <= 32'd0;
      else        tb_cnt <= tb_cnt + 32'd1;

   typedef struct {
      logic [47:0] cmd;  int ncmd;
      logic [47:0] rsp;  int nrsp;
      logic [3:0]  led;  bit tog;
   } vec_t;

   function automatic vec_t mk(logic [47:0] c, int nc, logic [47:0] r, int nr, logic [3:0] l, bit t);
      vec_t v;
      v.cmd = c; v.ncmd = nc; v.rsp = r; v.nrsp = nr; v.led = l; v.tog = t;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Offer one byte and return on the negedge after it is consumed.
   task automatic send(input logic [7:0] b);
      int n = 0;
      in_rd = b; in_rok = 1'b1;
      while (!in_r && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("send_wait", 0, 1);
      @(negedge clk);
      in_rok = 1'b0;
   endtask

   // Collect one response; dly = negedges from call until first out_w.
   task automatic collect(input bit tog, input int budget, output int dly);
      bit started = 0, ph = 0, pstall = 0, done = 0;
      logic [7:0] pwd = 8'h00;
      got.delete(); dly = -1;
      for (int k = 0; k < budget && !done; k++) begin
         @(negedge clk);
         if (pstall) chk("stall_hold", {7'd0, out_w, out_wd}, {7'd0, 1'b1, pwd});
         if (out_w && !started) begin started = 1; dly = k + 1; end
         if (started && !out_w) done = 1;
         else if (out_w) begin
            chk("no_rd_in_resp", in_r, 0);
            out_wok = tog ? ph : 1'b1;
            ph = ~ph;
            if (out_wok) got.push_back(out_wd);
            pstall = !out_wok; pwd = out_wd;
         end
      end
      out_wok = 1'b1;
      if (!done) chk("resp_timeout", 0, 1);
   endtask

   task automatic cmp_rsp(input string nm, input logic [47:0] r, input int nr);
      chk({nm, "_len"}, got.size(), nr);
      for (int j = 0; j < nr; j++)
         if (j < got.size()) chk(nm, got[j], r[8*(nr-1-j) +: 8]);
   endtask

   vec_t vt [13];

   initial begin
      int dly;
      logic [31:0] exp_cnt;
      logic [7:0]  exp8;
      bit anyw;

      vt[0]  = mk(48'h81,           1, 48'h8101,         2, 4'b0001, 0);
      vt[1]  = mk(48'h820A,         2, 48'h8201,         2, 4'b1010, 0);
      vt[2]  = mk(48'h82F5,         2, 48'h8201,         2, 4'b0101, 0);
      vt[3]  = mk(48'h80,           1, 48'h8001,         2, 4'b0100, 0);
      vt[4]  = mk(48'h8303AABBCC,   5, 48'h8301AABBCC,   5, 4'b0100, 1);
      vt[5]  = mk(48'h8310,         2, 48'h8304,         2, 4'b0100, 0);
      vt[6]  = mk(48'h81,           1, 48'h8101,         2, 4'b0101, 0);
      vt[7]  = mk(48'h8300,         2, 48'h8301,         2, 4'b0101, 1);
      vt[8]  = mk(48'h830401020304, 6, 48'h830101020304, 6, 4'b0101, 0);
      vt[9]  = mk(48'h8305,         2, 48'h8304,         2, 4'b0101, 0);
      vt[10] = mk(48'h7F,           1, 48'h7F02,         2, 4'b0101, 0);
      vt[11] = mk(48'h007F,         2, 48'h7F02,         2, 4'b0101, 0);
      vt[12] = mk(48'h85,           1, 48'h8502,         2, 4'b0101, 1);

      rst_n = 1'b0; in_rd = 8'h00; in_rok = 1'b0; out_wok = 1'b1;
      in_rok2 = 1'b0; out_wok2 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_r", in_r, 0);
      chk("rst_out_w", out_w, 0);
      chk("rst_busy", busy, 0);
      chk("rst_led", led, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_r", in_r, 1);

      for (int i = 0; i < 13; i++) begin
         for (int j = 0; j < vt[i].ncmd; j++) send(vt[i].cmd[8*(vt[i].ncmd-1-j) +: 8]);
         chk("exec_no_out_w", out_w, 0);
         chk("exec_busy", busy, 1);
         collect(vt[i].tog, 64, dly);
         chk("first_out_w_latency", dly, 1);
         cmp_rsp($sformatf("vec%0d", i), vt[i].rsp, vt[i].nrsp);
         chk($sformatf("vec%0d_led", i), led, vt[i].led);
         chk("busy_after", busy, 0);
      end

      // ReadCounter: payload is the counter value during the Exec cycle.
      send(8'h84);
      exp_cnt = tb_cnt;
      collect(1'b0, 64, dly);
      cmp_rsp("rdcnt", {16'h8401, exp_cnt}, 6);

      // Argument timeout: 1024 Arg cycles, Exec, then Resp.
      send(8'h82);
      collect(1'b0, 1200, dly);
      chk("timeout_latency", dly, 1025);
      cmp_rsp("timeout", 48'h8203, 2);
      chk("timeout_led", led, 4'b0101);

      // Counter wrap on the 8-bit instance (well over 256 cycles since reset).
      in_rd = 8'h84; in_rok2 = 1'b1;
      for (int k = 0; k < 20 && !in_r2; k++) @(negedge clk);
      @(negedge clk);
      in_rok2 = 1'b0;
      exp8 = tb_cnt[7:0];
      got.delete();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (out_w2) got.push_back(out_wd2);
      end
      cmp_rsp("wrap8", {24'h008401, exp8}, 3);

      // Reset in the middle of a stalled response.
      send(8'h83); send(8'h02); send(8'h11); send(8'h22);
      out_wok = 1'b0;
      @(negedge clk);
      chk("stalled_out_w", out_w, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_w", out_w, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_led", led, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      out_wok = 1'b1;
      anyw = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_w || busy) anyw = 1;
      end
      chk("postrst_quiet", anyw, 0);
      chk("postrst_in_r", in_r, 1);
      send(8'h81);
      collect(1'b0, 64, dly);
      cmp_rsp("postrst", 48'h8101, 2);
      chk("postrst_led", led, 4'b0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/debug_cmd_engine.md
Name: debug_cmd_engine

Overview:
Clock-domain-side command processor for the debug port. It pops command bytes from the inbound AFIFO read port and parses multi-byte commands (opcode plus arguments). It executes each command and pushes a framed response (opcode, status, payload) into the outbound AFIFO write port. It is a parametrised successor to the single-byte LED command handler, adding argument parsing, LED-vector width, a readable cycle counter, echo, an argument timeout and error status.

Parameters:
LEDCount, 4, width of led output (1..8)
CounterWidth, 32, free-running cycle counter width; multiple of 8, 8..64
EchoMax, 4, max echo payload bytes (1..15)
TimeoutCycles, 1024, max cycles waiting for each argument byte; 0 disables timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_r  out  1  inbound FIFO read trigger
in_rd  in  8  inbound FIFO read data; valid on cycles where in_r && in_rok
in_rok  in  1  inbound FIFO has data
out_w  out  1  outbound FIFO write trigger
out_wd  out  8  outbound FIFO write data; valid whenever out_w=1
out_wok  in  1  outbound FIFO accepts; byte transferred on cycles where out_w && out_wok
led  out  LEDCount  LED state
busy  out  1  high in any state other than Idle

Behaviour:
- Reset (async assert, sync release): led=0, in_r=0, out_w=0, busy=0, state=Idle, counter=0, response buffer count=0.
- Counter: free-running, +1 every cycle, wraps modulo 2^CounterWidth.
- Transfer rules: inbound byte consumed only when in_r && in_rok. Outbound byte sent only when out_w && out_wok. in_r and out_w are never both 1.
- States: Idle, Arg, Exec, Resp.
- Idle: in_r=1. On transfer: byte 0x00 (Nop) is dropped, stay Idle, no response. Any other byte is latched as opcode. Known opcodes with arguments go to Arg; all others go to Exec.
- Opcodes:
  - 0x80 LEDOff, 0 args: led[0]<=0.
  - 0x81 LEDOn, 0 args: led[0]<=1.
  - 0x82 LEDSet, 1 arg: led<=arg[LEDCount-1:0].
  - 0x83 Echo: first arg is length L, followed by L payload bytes.
  - 0x84 ReadCounter, 0 args.
  - Any other nonzero byte: status 0x02 (unknown).
- Arg: in_r=1. A per-byte timeout counter is cleared on each accepted byte.
  - If TimeoutCycles>0 and TimeoutCycles cycles pass without a transfer: status 0x03 (timeout), go to Exec. Bytes already received are discarded.
  - Echo with L>EchoMax: status 0x04 (bad length), no further bytes consumed, go to Exec.
  - Echo with L=0 is legal.
- Exec (exactly 1 cycle, in_r=0): apply the LED side effect only if status=0x01 (OK). Load the response buffer:
  - byte0 = opcode, byte1 = status.
  - ReadCounter payload: counter value sampled in this cycle, MSB byte first, CounterWidth/8 bytes.
  - Echo payload: the L bytes in received order.
  - Error responses carry no payload.
- Resp: out_w=1, out_wd = current buffer byte. Advance the index on out_wok. After the last byte transfers, out_w falls on the next cycle and the state returns to Idle. Stalls indefinitely while out_wok=0, holding out_wd stable.
- Latency: a 0-arg command byte accepted in cycle N gives Exec at N+1 and the first out_w at N+2.
- Back-pressure: no inbound read occurs during Exec or Resp. Commands are processed strictly in order.
- Reset mid-operation returns immediately to the reset state. A partial response is abandoned; no partial bytes are emitted after release.

Test Plan:
- Reset, then push 0x81 with out_wok=1 -> led[0]=1 two cycles later. Outbound gets 0x81, 0x01. busy returns to 0.
- Push 0x82, 0x0A with LEDCount=4 -> led=4'b1010. Response 0x82, 0x01.
- Push 0x84 with counter forced near 0xFFFFFFFF (wrap) -> response 0x84, 0x01 plus 4 bytes MSB first, equal to the counter value at Exec. Assert ordering and the wrap value.
- Push 0x83, 0x03, 0xAA, 0xBB, 0xCC while toggling out_wok every cycle -> outbound exactly 0x83, 0x01, 0xAA, 0xBB, 0xCC. out_wd stable during stalls. No in_r during Resp.
- Push 0x83, 0x10 (EchoMax=4) -> response 0x83, 0x04. Next byte 0x81 is treated as a new opcode. Push 0x82 then starve in_rok for 1024 cycles -> response 0x82, 0x03, led unchanged.
- Push 0x00, 0x7F -> no response for Nop. Response 0x7F, 0x02 for unknown. Assert rst_n low mid-Resp -> out_w=0 immediately, state Idle after release.
